// File: rtl/sr_reg_dump_if.sv
// Debug register port plus byte-stream handshake between sr_reg_dump and its neighbours.
// master = the dump engine (drives regAddr and the stream), slave = CPU/sink side.
interface sr_reg_dump_if;
   logic [4:0]  regAddr;
   logic [31:0] regData;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output regAddr,
      input  regData,
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  regAddr,
      output regData,
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/sr_reg_dump.sv
// Sweeps the CPU debug register port over FIRST_REG..LAST_REG and streams
// each register as a header byte (its index) followed by four data bytes, MSB first.
module sr_reg_dump #(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   sr_reg_dump_if.master bus,
   output logic         busy,
   output logic         done
);

   localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
   localparam logic [4:0] LAST_A  = 5'(LAST_REG);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_CAP,
      S_SEND,
      S_DONE
   } state_t;

   state_t      state, state_nxt;
   logic [4:0]  reg_addr, addr_nxt;
   logic [31:0] shadow, shadow_nxt;
   logic [2:0]  byte_idx, idx_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         reg_addr <= '0;
         shadow   <= '0;
         byte_idx <= '0;
      end else begin
         state    <= state_nxt;
         reg_addr <= addr_nxt;
         shadow   <= shadow_nxt;
         byte_idx <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      addr_nxt   = reg_addr;
      shadow_nxt = shadow;
      idx_nxt    = byte_idx;
      case (state)
         S_IDLE: begin
            if (start) begin
               addr_nxt  = FIRST_A;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: state_nxt = S_CAP;
         S_CAP: begin
            shadow_nxt = bus.regData;
            idx_nxt    = '0;
            state_nxt  = S_SEND;
         end
         S_SEND: begin
            if (bus.out_ready) begin
               if (byte_idx != 3'd4) begin
                  idx_nxt = byte_idx + 3'd1;
               end else if (reg_addr == LAST_A) begin
                  state_nxt = S_DONE;
               end else begin
                  addr_nxt  = reg_addr + 5'd1;
                  state_nxt = S_WAIT;
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decode registered state only; out_data is forced to zero outside SEND.
   always_comb begin
      bus.regAddr   = reg_addr;
      bus.out_valid = (state == S_SEND);
      busy          = (state != S_IDLE);
      done          = (state == S_DONE);
      bus.out_data  = '0;
      if (state == S_SEND) begin
         case (byte_idx)
            3'd0:    bus.out_data = {3'b000, reg_addr};
            3'd1:    bus.out_data = shadow[31:24];
            3'd2:    bus.out_data = shadow[23:16];
            3'd3:    bus.out_data = shadow[15:8];
            3'd4:    bus.out_data = shadow[7:0];
            default: bus.out_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_reg_dump.sv
// Directed/random bench for sr_reg_dump: expected streams come from a byte-queue model
// built from the register-file array and the dump rules.
module tb_sr_reg_dump;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        sel;
   logic        out_ready;
   logic [31:0] regs [32];
   int          n_assert = 0;
   int          n_fail   = 0;

   logic start_a, start_b, busy_a, done_a, busy_b, done_b;
   logic [7:0] o_data;
   logic [4:0] o_addr;
   logic       o_valid, o_busy, o_done;

   sr_reg_dump_if bus_a ();
   sr_reg_dump_if bus_b ();

   assign bus_a.regData   = regs[bus_a.regAddr];
   assign bus_b.regData   = regs[bus_b.regAddr];
   assign bus_a.out_ready = out_ready;
   assign bus_b.out_ready = out_ready;
   assign start_a = start & ~sel;
   assign start_b = start & sel;

   assign o_data  = sel ? bus_b.out_data  : bus_a.out_data;
   assign o_addr  = sel ? bus_b.regAddr   : bus_a.regAddr;
   assign o_valid = sel ? bus_b.out_valid : bus_a.out_valid;
   assign o_busy  = sel ? busy_b : busy_a;
   assign o_done  = sel ? done_b : done_a;

   sr_reg_dump dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_a),
      .bus   (bus_a.master),
      .busy  (busy_a),
      .done  (done_a)
   );

   sr_reg_dump #(.FIRST_REG(5), .LAST_REG(7)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_b),
      .bus   (bus_b.master),
      .busy  (busy_b),
      .done  (done_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // mode: 0 ready always, 1 alternate 1,0 in SEND, 2 random
   task automatic run_dump(input int first, input int last, input int mode,
                           input int swap_at, input bit repulse);
      logic [7:0] exp_q [$];
      logic [7:0] held;
      int n, nbytes, got, stalls, cyc, budget;
      bit stalled, phase, done_seen;
      n = last - first + 1;
      nbytes = 5 * n;
      budget = 20 * n + 10;
      got = 0; stalls = 0; stalled = 0; phase = 1'b1; done_seen = 0; held = '0;
      for (int r = first; r <= last; r++) begin
         exp_q.push_back(8'(r));
         exp_q.push_back(regs[r][31:24]);
         exp_q.push_back(regs[r][23:16]);
         exp_q.push_back(regs[r][15:8]);
         exp_q.push_back(regs[r][7:0]);
      end
      start = 1'b1;
      cyc = 0;
      chk("idle_busy", {31'd0, o_busy}, 32'd0);
      tick();
      start = 1'b0;
      cyc = 1;
      while (!done_seen && cyc <= budget) begin
         if (repulse) start = (cyc == 3 || cyc == 50);
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = o_valid ? phase : 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         chk("busy", {31'd0, o_busy}, 32'd1);
         if (mode == 0 && cyc == 3) chk("first_valid", {31'd0, o_valid}, 32'd1);
         if (o_valid) begin
            if (stalled) chk("stall_stable", {24'd0, o_data}, {24'd0, held});
            if (out_ready) begin
               if (got < exp_q.size()) chk("byte", {24'd0, o_data}, {24'd0, exp_q[got]});
               else chk("extra_byte", got, exp_q.size());
               got++;
               stalled = 0;
               if (got == swap_at) begin
                  for (int r = 0; r < 32; r++) regs[r] = 32'h2222_2222;
                  for (int k = 5; k < exp_q.size(); k++)
                     if (k % 5 != 0) exp_q[k] = 8'h22;
               end
            end else begin
               stalls++;
               stalled = 1;
               held = o_data;
            end
            if (mode == 1) phase = ~phase;
         end
         if (o_done) begin
            done_seen = 1;
            chk("byte_count", got, nbytes);
            chk("done_cycle", cyc, 7 * n + 1 + stalls);
         end else begin
            tick();
            cyc++;
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      if (!done_seen) chk("done_timeout", {31'd0, done_seen}, 32'd1);
      tick();
      chk("idle_after", {31'd0, o_busy}, 32'd0);
   endtask

   initial begin
      int cyc, got;
      bit seen;
      rst_n = 1'b0; start = 1'b0; sel = 1'b0; out_ready = 1'b1;
      for (int r = 0; r < 32; r++) regs[r] = 32'hA500_0000 | r;
      #12;
      chk("rst_busy",  {31'd0, busy_a}, 32'd0);
      chk("rst_done",  {31'd0, done_a}, 32'd0);
      chk("rst_valid", {31'd0, bus_a.out_valid}, 32'd0);
      chk("rst_addr",  {27'd0, bus_a.regAddr}, 32'd0);
      chk("rst_data",  {24'd0, bus_a.out_data}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      run_dump(0, 31, 0, -1, 0);
      run_dump(0, 31, 1, -1, 0);
      for (int r = 0; r < 32; r++) regs[r] = $urandom;
      run_dump(0, 31, 2, -1, 1);

      sel = 1'b1;
      run_dump(5, 7, 0, -1, 0);
      run_dump(5, 7, 2, -1, 0);

      // start held high through DONE re-triggers on the following cycle
      start = 1'b1;
      cyc = 0; seen = 0;
      while (!seen && cyc < 40) begin
         if (o_done) seen = 1;
         else begin tick(); cyc++; end
      end
      chk("held_done_cycle", cyc, 22);
      tick();
      chk("held_idle", {31'd0, o_busy}, 32'd0);
      tick();
      chk("held_rebusy", {31'd0, o_busy}, 32'd1);
      chk("held_addr", {27'd0, o_addr}, 32'd5);
      start = 1'b0;
      cyc = 0; seen = 0;
      while (!seen && cyc < 40) begin
         if (o_done) seen = 1;
         else begin tick(); cyc++; end
      end
      chk("held_second_done", {31'd0, seen}, 32'd1);
      tick();

      // async reset in SEND with byte_idx = 2
      sel = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      got = 0; cyc = 0;
      while (got < 2 && cyc < 20) begin
         if (o_valid) got++;
         if (got < 2) begin tick(); cyc++; end
      end
      tick();
      chk("pre_rst_valid", {31'd0, o_valid}, 32'd1);
      chk("pre_rst_byte", {24'd0, o_data}, {24'd0, regs[0][23:16]});
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, o_valid}, 32'd0);
      chk("arst_busy",  {31'd0, o_busy}, 32'd0);
      chk("arst_addr",  {27'd0, o_addr}, 32'd0);
      chk("arst_data",  {24'd0, o_data}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_dump(0, 31, 0, -1, 0);

      // regData changes during SEND after capture
      for (int r = 0; r < 32; r++) regs[r] = 32'h1111_1111;
      run_dump(0, 31, 0, 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
